// File: rtl/piso_pkg.sv
// piso_pkg
// Shared types and helpers for the parallel-in/serial-out framer.
//   piso_state_t : FSM encoding (IDLE = shifter empty, SHIFT = emitting bits)
//   next_bit_idx : maps the frame bit counter onto a word bit index
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  // The bit counter runs WIDTH-1 down to 0 while a frame is on the wire.
  // This returns the word index of the bit presented when the counter
  // steps to cnt-1. Passing cnt == width gives the first bit of a frame.
  function automatic int next_bit_idx(input bit msb_first, input int width,
                                      input int cnt);
    return msb_first ? (cnt - 1) : (width - cnt);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// piso_hold_reg
// One-entry holding register used to park the next word while the shifter
// is still busy with the current frame.
//   clk    : rising-edge clock
//   reset  : synchronous, active-low reset (clears full_o)
//   wr_en  : capture data_i and mark full (wins over rd_en)
//   rd_en  : the parent has moved the stored word into its shifter
//   data_i : word to capture
//   data_o : stored word
//   full_o : a word is waiting
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  // A simultaneous read and write hands the old word out and keeps the
  // register occupied with the new one, so write takes priority for full_o.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full_o <= 1'b0;
      data_o <= '0;
    end else if (wr_en) begin
      full_o <= 1'b1;
      data_o <= data_i;
    end else if (rd_en) begin
      full_o <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in/serial-out framer. Accepts WIDTH-bit words on a valid/ready
// handshake and emits them one bit per clock with start/end-of-frame marks.
// A one-entry holding register lets consecutive frames run with no gap.
//   clk     : rising-edge clock
//   reset   : synchronous, active-low reset
//   data_i  : parallel word
//   valid_i : data_i is valid
//   ready_o : a word can be accepted this cycle (holding register empty)
//   x_o     : serial bit (IDLE_BIT between frames)
//   x_vld_o : x_o carries a frame bit
//   sof_o   : first bit of a frame
//   eof_o   : last bit of a frame
//   busy_o  : shifter active or holding register full
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH     = 4,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_vld_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  piso_state_t      state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] word_q, word_n;
  logic             x_n, vld_n, sof_n, eof_n;

  logic             hold_full, hold_wr, hold_rd;
  logic [WIDTH-1:0] hold_data;

  logic             xfer, load_slot;
  logic [CW-1:0]    first_idx, next_idx;

  assign ready_o   = !hold_full;
  assign busy_o    = (state_q == SHIFT) || hold_full;
  assign xfer      = valid_i && !hold_full;
  // The shifter can take a new word when empty or while its last bit is out.
  assign load_slot = (state_q == IDLE) || (cnt_q == '0);
  assign first_idx = CW'(next_bit_idx(MSB_FIRST, WIDTH, WIDTH));
  assign next_idx  = CW'(next_bit_idx(MSB_FIRST, WIDTH, int'(cnt_q)));

  piso_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (hold_wr),
    .rd_en  (hold_rd),
    .data_i (data_i),
    .data_o (hold_data),
    .full_o (hold_full)
  );

  // Next-state and registered-output logic. At a load slot a waiting word
  // has priority over data_i; otherwise data_i bypasses the holding
  // register. Mid-frame, an accepted word is parked in the holding register.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    word_n  = word_q;
    x_n     = IDLE_BIT;
    vld_n   = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    hold_wr = 1'b0;
    hold_rd = 1'b0;

    if (load_slot) begin
      if (hold_full) begin
        hold_rd = 1'b1;
        hold_wr = xfer;
        state_n = SHIFT;
        cnt_n   = LAST_CNT;
        word_n  = hold_data;
        x_n     = hold_data[first_idx];
        vld_n   = 1'b1;
        sof_n   = 1'b1;
      end else if (xfer) begin
        state_n = SHIFT;
        cnt_n   = LAST_CNT;
        word_n  = data_i;
        x_n     = data_i[first_idx];
        vld_n   = 1'b1;
        sof_n   = 1'b1;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end else begin
      hold_wr = xfer;
      cnt_n   = cnt_q - ONE_CNT;
      x_n     = word_q[next_idx];
      vld_n   = 1'b1;
      eof_n   = (cnt_q == ONE_CNT);
    end
  end

  // State, counter, word and output registers. Reset drops any frame in
  // flight without marking its end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      x_o     <= IDLE_BIT;
      x_vld_o <= 1'b0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      word_q  <= word_n;
      x_o     <= x_n;
      x_vld_o <= vld_n;
      sof_o   <= sof_n;
      eof_o   <= eof_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Self-checking bench for piso_serializer. dut4 is WIDTH=4 MSB-first and
// feeds a 4-bit downstream shift register model; dut8 is WIDTH=8 LSB-first.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] data4;
  logic       valid4, ready4, x4, xv4, sof4, eof4, busy4;
  logic [7:0] data8;
  logic       valid8, ready8, x8, xv8, sof8, eof8, busy8;

  logic [3:0] sr;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  // Monitor of dut4 frame bits: {sof, eof, x} plus the cycle it appeared in.
  logic [2:0] mon_q[$];
  int         mon_cyc[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut4 (
    .clk(clk), .reset(reset), .data_i(data4), .valid_i(valid4),
    .ready_o(ready4), .x_o(x4), .x_vld_o(xv4), .sof_o(sof4), .eof_o(eof4),
    .busy_o(busy4)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut8 (
    .clk(clk), .reset(reset), .data_i(data8), .valid_i(valid8),
    .ready_o(ready8), .x_o(x8), .x_vld_o(xv8), .sof_o(sof8), .eof_o(eof8),
    .busy_o(busy8)
  );

  // Downstream 4-bit serial shift register fed from dut4, plus a cycle count.
  always @(posedge clk) begin
    sr  <= {sr[2:0], x4};
    cyc <= cyc + 1;
  end

  // Record every valid dut4 frame bit away from the active edge.
  always @(negedge clk) begin
    if (xv4 === 1'b1) begin
      mon_q.push_back({sof4, eof4, x4});
      mon_cyc.push_back(cyc);
    end
  end

  // Reference: bit k of a frame carrying word w.
  function automatic logic frame_bit(input logic [7:0] w, input int width,
                                     input bit msb, input int k);
    logic [7:0] s;
    s = w >> (msb ? (width - 1 - k) : k);
    return s[0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_q.delete();
    mon_cyc.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    valid4 = 1'b1;
    data4  = 4'($urandom);
    valid8 = 1'b1;
    data8  = 8'($urandom);
    step();
    step();
    reset  = 1'b1;
    valid4 = 1'b0;
    valid8 = 1'b0;
    checks++;
    if ({ready4, xv4, x4, sof4, eof4, busy4} !== 6'b100000) begin
      failures++;
      $display("[TB] FAIL reset_outputs4 got=%b exp=%b",
               {ready4, xv4, x4, sof4, eof4, busy4}, 6'b100000);
    end
    checks++;
    if ({ready8, xv8, x8, sof8, eof8, busy8} !== 6'b100000) begin
      failures++;
      $display("[TB] FAIL reset_outputs8 got=%b exp=%b",
               {ready8, xv8, x8, sof8, eof8, busy8}, 6'b100000);
    end
    step();
    step();
    checks++;
    if (mon_q.size() !== 0 || busy4 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_no_transfer got_bits=%0d busy=%b%b exp_bits=0 busy=00",
               mon_q.size(), busy4, busy8);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic       ex, es, ee;
    w = 8'b0000_1011;
    data4  = 4'b1011;
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    data4  = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      ex = frame_bit(w, 4, 1'b1, i);
      es = (i == 0);
      ee = (i == 3);
      checks++;
      if ({xv4, x4, sof4, eof4} !== {1'b1, ex, es, ee}) begin
        failures++;
        $display("[TB] FAIL single_bit%0d got vld/x/sof/eof=%b exp=%b",
                 i, {xv4, x4, sof4, eof4}, {1'b1, ex, es, ee});
      end
    end
    step();
    checks++;
    if ({xv4, x4, sof4, eof4, busy4} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL single_idle got=%b exp=%b",
               {xv4, x4, sof4, eof4, busy4}, 5'b00000);
    end
    checks++;
    if (sr !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL single_downstream_sr got=%b exp=%b", sr, 4'b1011);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic       ex, es, ee, er;
    int         k;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        data4  = 4'hA;
        valid4 = 1'b1;
      end else if (i == 1) begin
        data4 = 4'h5;
      end else begin
        valid4 = 1'b0;
      end
      step();
      k  = i % 4;
      w  = (i < 4) ? 8'h0A : 8'h05;
      ex = frame_bit(w, 4, 1'b1, k);
      es = (k == 0);
      ee = (k == 3);
      er = !(i >= 1 && i <= 3);
      checks++;
      if ({xv4, x4, sof4, eof4, ready4} !== {1'b1, ex, es, ee, er}) begin
        failures++;
        $display("[TB] FAIL b2b_cycle%0d got vld/x/sof/eof/ready=%b exp=%b",
                 i, {xv4, x4, sof4, eof4, ready4}, {1'b1, ex, es, ee, er});
      end
    end
    step();
    checks++;
    if ({xv4, busy4, ready4} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL b2b_idle got vld/busy/ready=%b exp=%b",
               {xv4, busy4, ready4}, 3'b001);
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    logic take;
    logic contiguous;
    logic [7:0] w;
    logic [2:0] exp_e;
    clear_mon();
    acc    = 0;
    data4  = 4'd1;
    valid4 = 1'b1;
    for (int c = 0; c < 40 && acc < 3; c++) begin
      take = valid4 && ready4;
      step();
      if (take) begin
        acc++;
        if (acc < 3) data4 = 4'(acc + 1);
        else valid4 = 1'b0;
      end
    end
    valid4 = 1'b0;
    checks++;
    if (acc !== 3) begin
      failures++;
      $display("[TB] FAIL bp_accept_count got=%0d exp=3", acc);
    end
    for (int c = 0; c < 50 && busy4; c++) step();
    step();
    checks++;
    if (busy4 !== 1'b0 || mon_q.size() !== 12) begin
      failures++;
      $display("[TB] FAIL bp_stream_len got busy=%b bits=%0d exp busy=0 bits=12",
               busy4, mon_q.size());
    end
    contiguous = 1'b1;
    for (int i = 0; i < mon_q.size() && i < 12; i++) begin
      w     = 8'((i / 4) + 1);
      exp_e = {(i % 4) == 0, (i % 4) == 3, frame_bit(w, 4, 1'b1, i % 4)};
      if (mon_cyc[i] != mon_cyc[0] + i) contiguous = 1'b0;
      checks++;
      if (mon_q[i] !== exp_e) begin
        failures++;
        $display("[TB] FAIL bp_bit%0d got sof/eof/x=%b exp=%b", i, mon_q[i], exp_e);
      end
    end
    checks++;
    if (contiguous !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_contiguous got=%b exp=1", contiguous);
    end
  endtask

  task automatic test_reset_mid();
    int eofs;
    clear_mon();
    data4  = 4'hF;
    valid4 = 1'b1;
    step();
    data4 = 4'h3;
    step();
    valid4 = 1'b0;
    checks++;
    if ({ready4, busy4} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL mid_hold_full got ready/busy=%b exp=%b", {ready4, busy4}, 2'b01);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({xv4, x4, sof4, eof4, busy4, ready4} !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL mid_reset_idle got=%b exp=%b",
               {xv4, x4, sof4, eof4, busy4, ready4}, 6'b000001);
    end
    repeat (10) step();
    eofs = 0;
    foreach (mon_q[i]) if (mon_q[i][1]) eofs++;
    checks++;
    if (mon_q.size() !== 2 || eofs !== 0 || busy4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_aborted got bits=%0d eofs=%0d busy=%b exp bits=2 eofs=0 busy=0",
               mon_q.size(), eofs, busy4);
    end
  endtask

  task automatic test_lsb8();
    logic [7:0] w;
    logic       ex, es, ee;
    w      = 8'hC1;
    data8  = 8'hC1;
    valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    data8  = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      ex = frame_bit(w, 8, 1'b0, i);
      es = (i == 0);
      ee = (i == 7);
      checks++;
      if ({xv8, x8, sof8, eof8} !== {1'b1, ex, es, ee}) begin
        failures++;
        $display("[TB] FAIL lsb8_bit%0d got vld/x/sof/eof=%b exp=%b",
                 i, {xv8, x8, sof8, eof8}, {1'b1, ex, es, ee});
      end
    end
    step();
    checks++;
    if ({xv8, x8, busy8, ready8} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL lsb8_idle got=%b exp=%b", {xv8, x8, busy8, ready8}, 4'b0001);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_words[$];
    logic [2:0] exp_e;
    logic       take;
    int         n;
    clear_mon();
    for (int c = 0; c < 300; c++) begin
      valid4 = ($urandom_range(0, 3) != 0);
      data4  = 4'($urandom);
      take   = valid4 && ready4;
      if (take) exp_words.push_back({4'b0000, data4});
      step();
    end
    valid4 = 1'b0;
    for (int c = 0; c < 50 && busy4; c++) step();
    step();
    n = exp_words.size() * 4;
    checks++;
    if (busy4 !== 1'b0 || mon_q.size() !== n) begin
      failures++;
      $display("[TB] FAIL rand_stream_len got busy=%b bits=%0d exp busy=0 bits=%0d",
               busy4, mon_q.size(), n);
    end
    for (int i = 0; i < mon_q.size() && i < n; i++) begin
      exp_e = {(i % 4) == 0, (i % 4) == 3,
               frame_bit(exp_words[i / 4], 4, 1'b1, i % 4)};
      checks++;
      if (mon_q[i] !== exp_e) begin
        failures++;
        $display("[TB] FAIL rand_bit%0d got sof/eof/x=%b exp=%b", i, mon_q[i], exp_e);
      end
    end
  endtask

  // Test sequence; each scenario leaves both DUTs idle for the next one.
  initial begin
    reset  = 1'b0;
    valid4 = 1'b0;
    valid8 = 1'b0;
    data4  = '0;
    data8  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_lsb8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out framer that sits directly upstream of the 4-bit serial shift register. It accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto the shift register's serial input, with frame markers. A one-entry holding register allows back-to-back frames with no idle bit between them. With WIDTH=4 and MSB_FIRST=1, the downstream register's `sr_o` equals the transmitted word on the cycle after `eof_o`.

## Interface
- `WIDTH`, 4, word width in bits; legal values are WIDTH ≥ 2.
- `MSB_FIRST`, 1, bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- `IDLE_BIT`, 1'b0, value driven on `x_o` while no frame is active.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `data_i`  in  WIDTH  parallel word.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `x_o`  out  1  serial bit; connects to the downstream `x_i`.
- `x_vld_o`  out  1  `x_o` carries a frame bit.
- `sof_o`  out  1  first bit of a frame.
- `eof_o`  out  1  last bit of a frame.
- `busy_o`  out  1  shifter active or holding register full.

## Operation
- A transfer occurs on a rising edge when `valid_i && ready_o` are both high.
- `ready_o = !hold_full`. It is derived only from registered state and never depends on `valid_i`.
- There are two FSM states:
  - IDLE: shifter empty.
  - SHIFT: shifter is emitting bits and `bit_cnt` counts from WIDTH-1 down to 0.
- Load rule (shifter-load): in IDLE, or in SHIFT with `bit_cnt==0`:
  - If `hold_full`, load the shifter from the holding register and clear `hold_full`. If a transfer occurs in the same cycle, it writes the holding register and `hold_full` stays set.
  - Otherwise, if a transfer occurs, load `data_i` directly into the shifter, bypassing the holding register.
  - Otherwise go to (or stay in) IDLE.
- Capture rule: in SHIFT with `bit_cnt != 0`, a transfer writes the holding register and sets `hold_full`.
- All outputs are registered:
  - After a load, `x_o` presents the first bit, `sof_o=1` and `x_vld_o=1`.
  - Each following cycle presents the next bit.
  - `eof_o=1` with the final bit.
- If `sof_o` and `eof_o` could coincide, WIDTH=1 would be required; that width is illegal.
- In IDLE: `x_o=IDLE_BIT` and `x_vld_o=sof_o=eof_o=0`.
- `busy_o` = (state==SHIFT) || `hold_full`.
- Back-to-back: when the holding register or `data_i` is available at the last bit, the next frame's `sof_o` immediately follows the previous `eof_o`. There is no gap cycle.
- `data_i` is ignored when `valid_i` is low. A word is never accepted while `ready_o` is low.

## Timing
- Reset (`reset==0` at a rising edge) gives, from the next cycle:
  - state IDLE, `hold_full=0`, `bit_cnt=0`;
  - `x_o=IDLE_BIT`;
  - `x_vld_o=sof_o=eof_o=busy_o=0`;
  - `ready_o=1`.
- Reset mid-frame aborts the frame and discards the holding register. No `eof_o` is emitted for the aborted frame.
- Latency: a word accepted at edge N (block idle) shows its first bit after edge N and its last bit after edge N+WIDTH-1.
- Throughput: one word per WIDTH cycles sustained.
- `ready_o` behaviour:
  - It drops for the cycle after a capture into the holding register.
  - It rises again in the cycle after the holding register is moved into the shifter.
- Simultaneous events:
  - Last bit + `hold_full` + `valid_i`: the holding word moves to the shifter. The new `data_i` is not accepted, because `ready_o` is low.
  - Last bit + empty holding register + transfer: direct load, no bubble, `ready_o` stays 1.

## Structure
- Package `piso_pkg` contains:
  - `typedef enum logic {IDLE, SHIFT} piso_state_t`;
  - a function returning the next bit index for a given `MSB_FIRST`.
- Counter width is `$clog2(WIDTH)`.
- Sub-module `piso_hold_reg` is the one-entry holding register with a `full` flag. Its write and read enables come from the parent FSM.
- The shifter, counter and FSM stay in the top module.

## Test plan
- Reset check: hold `reset=0` for 2 cycles with `valid_i=1`, then release. Required: `ready_o=1`, `x_vld_o=0`, `x_o=IDLE_BIT`, and no transfer during reset.
- Single frame, WIDTH=4, MSB_FIRST=1: send 4'b1011 at edge N.
  - `x_o` is 1,0,1,1 after edges N..N+3.
  - `sof_o` is high only after N; `eof_o` is high only after N+3.
  - After N+4: idle, and a connected shift register shows `sr_o=4'b1011`.
- Back-to-back: send 4'hA, then 4'h5 on the next cycle with `valid_i` held high.
  - Required: 8 consecutive valid bits 1,0,1,0,0,1,0,1.
  - `eof_o` of frame 1 is followed immediately by `sof_o` of frame 2.
  - `ready_o` is low from the cycle after 4'h5 is captured until the cycle after the handover.
- Backpressure: hold `valid_i` high with words 1,2,3.
  - Word 3 waits while `ready_o=0` and is accepted exactly once.
  - Output shows 3 contiguous frames in order.
- Reset mid-frame: assert reset after bit 2 of 4'hF while 4'h3 sits in the holding register.
  - Required: idle outputs next cycle, no `eof_o`, and 4'h3 is never transmitted.
- LSB-first (MSB_FIRST=0, WIDTH=8): send 8'hC1.
  - `x_o` is 1,0,0,0,0,0,1,1.
  - `eof_o` is high on the 8th bit.
